// File: rtl/fetch_sequencer_if.sv
// ROM read port of the fetch sequencer: request/address out, ack/data back.
// The sequencer holds rom_req and rom_addr steady until the ROM acks.
interface fetch_sequencer_if #(
  parameter int INSN_WIDTH = 9,
  parameter int PC_WIDTH   = 8
) ();
  logic                  rom_req;
  logic [PC_WIDTH-1:0]   rom_addr;
  logic                  rom_ack;
  logic [INSN_WIDTH-1:0] rom_data;

  modport master (
    output rom_req,
    output rom_addr,
    input  rom_ack,
    input  rom_data
  );

  modport slave (
    input  rom_req,
    input  rom_addr,
    output rom_ack,
    output rom_data
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, fetches over the ROM req/ack port, shows each word for one EXEC cycle.
// Two cycles per instruction plus one per ROM wait cycle; a slow ROM just holds the request and address.
module fetch_sequencer #(
  parameter int INSN_WIDTH = 9,
  parameter int DATA_WIDTH = 8,
  parameter int PC_WIDTH   = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  fetch_sequencer_if.master     rom,
  output logic [INSN_WIDTH-1:0] insn_out,
  output logic                  insn_valid,
  input  logic                  halt,
  input  logic                  branch,
  input  logic                  jump,
  input  logic                  relative,
  input  logic [DATA_WIDTH-1:0] destBranchJump,
  input  logic                  compare_flag,
  output logic [PC_WIDTH-1:0]   pc,
  output logic                  halted,
  output logic [CNT_WIDTH-1:0]  insn_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_EXEC,
    ST_HALTED
  } state_e;

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSN_WIDTH-1:0]  insn_q, insn_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [PC_WIDTH-1:0]    pc_next;
  logic [PC_WIDTH-1:0]    rel_off;
  logic                   taken;
  logic                   rom_req_c;

  // Relative targets are taken from the branch's own address, so pc_q is the base.
  always_comb begin
    taken   = jump | (branch & compare_flag);
    rel_off = PC_WIDTH'($signed(destBranchJump));
    pc_next = pc_q + PC_WIDTH'(1);
    if (taken) begin
      if (relative) begin
        pc_next = pc_q + rel_off;
      end else begin
        pc_next = PC_WIDTH'(destBranchJump);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    insn_d     = insn_q;
    cnt_d      = cnt_q;
    rom_req_c  = 1'b0;
    insn_valid = 1'b0;
    halted     = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        halted = (state_q == ST_HALTED);
        if (start) begin
          pc_d    = '0;
          cnt_d   = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        rom_req_c = 1'b1;
        if (rom.rom_ack) begin
          insn_d  = rom.rom_data;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        insn_valid = 1'b1;
        // A halting instruction still retires and is counted.
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
        if (halt) begin
          state_d = ST_HALTED;
        end else begin
          pc_d    = pc_next;
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      insn_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      insn_q  <= insn_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rom.rom_req  = rom_req_c;
  assign rom.rom_addr = pc_q;
  assign insn_out     = insn_q;
  assign pc           = pc_q;
  assign insn_count   = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a ROM model and a table-driven control unit feed the DUT,
// a program-level model predicts the executed instruction trace, and a monitor scores it.
module tb_fetch_sequencer;

  localparam int MAXS = 24;

  logic        clk;
  logic        reset;
  logic        start;
  logic [8:0]  insn_out;
  logic        insn_valid;
  logic        halt_s, branch_s, jump_s, rel_s, cmp_s;
  logic [7:0]  dest_s;
  logic [7:0]  pc;
  logic        halted;
  logic [15:0] insn_count;

  fetch_sequencer_if #(.INSN_WIDTH(9), .PC_WIDTH(8)) rom_bus ();

  fetch_sequencer #(
    .INSN_WIDTH(9), .DATA_WIDTH(8), .PC_WIDTH(8), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .rom(rom_bus),
    .insn_out(insn_out), .insn_valid(insn_valid),
    .halt(halt_s), .branch(branch_s), .jump(jump_s), .relative(rel_s),
    .destBranchJump(dest_s), .compare_flag(cmp_s),
    .pc(pc), .halted(halted), .insn_count(insn_count)
  );

  logic [8:0] rom_mem  [256];
  logic [7:0] dest_tab [64];

  // Control unit stand-in: decodes whatever insn_out holds, in every state.
  assign halt_s   = (insn_out[8:6] == 3'b111) && insn_out[0];
  assign jump_s   = insn_out[8];
  assign branch_s = insn_out[7];
  assign rel_s    = insn_out[6];
  assign cmp_s    = insn_out[5];
  assign dest_s   = dest_tab[insn_out[5:0]];

  typedef struct {
    int         pc;
    logic [8:0] insn;
    int         idx;
  } exp_t;

  exp_t exp_q[$];
  int   wq[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   last_exec = 0;
  bit   rand_waits = 0;
  bit   force_ack = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic logic [8:0] mk(input bit j, input bit b, input bit r, input int idx);
    logic [5:0] i6;
    i6 = 6'(idx);
    return {j, b, r, i6};
  endfunction

  // Program-level model: walk the ROM from address 0 and record every executed word.
  task automatic build(output bit hs, output int hpc, output int cnt);
    int         p, off, d;
    logic [8:0] w;
    bit         tk;
    p   = 0;
    hs  = 0;
    hpc = 0;
    cnt = MAXS;
    for (int i = 0; i < MAXS; i++) begin
      w = rom_mem[p];
      exp_q.push_back('{pc: p, insn: w, idx: i});
      if (w[8:6] == 3'b111 && w[0]) begin
        hs  = 1;
        hpc = p;
        cnt = i + 1;
        return;
      end
      d  = int'(dest_tab[w[5:0]]);
      tk = w[8] || (w[7] && w[5]);
      if (!tk) begin
        p = (p + 1) % 256;
      end else if (!w[6]) begin
        p = d;
      end else begin
        off = (d >= 128) ? d - 256 : d;
        p   = (p + off + 256) % 256;
      end
    end
  endtask

  task automatic fill_plain();
    for (int a = 0; a < 256; a++) rom_mem[a] = {3'b000, 6'($urandom)};
    for (int a = 0; a < 64; a++) dest_tab[a] = 8'($urandom);
  endtask

  task automatic fill_random();
    for (int a = 0; a < 256; a++) rom_mem[a] = 9'($urandom);
    for (int a = 0; a < 64; a++) dest_tab[a] = 8'($urandom);
  endtask

  task automatic do_run();
    bit hs;
    int hpc, cnt, t;
    exp_q.delete();
    wq.delete();
    build(hs, hpc, cnt);
    @(negedge clk);
    start     = 1'b1;
    start_cyc = cyc;
    t = 0;
    do begin
      @(negedge clk);
      start = ($urandom_range(0, 5) == 0);
      t++;
    end while (exp_q.size() != 0 && t < 2000);
    start = 1'b0;
    if (t >= 2000) begin
      chk("run_timeout", 1, 0);
      exp_q.delete();
      wq.delete();
      hs = 0;
    end
    if (hs) begin
      repeat (10) begin
        @(negedge clk);
        chk("halted_flag", halted, 1);
        chk("halted_rom_req", rom_bus.rom_req, 0);
        chk("halted_pc", pc, hpc);
        chk("halted_count", insn_count, cnt);
      end
    end else begin
      // Stop a non-halting program while the ROM is stalled, with start colliding with reset.
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      start = 1'b1;
      @(negedge clk);
      reset     = 1'b0;
      start     = 1'b0;
      force_ack = 1'b1;
      repeat (4) begin
        chk("rst_rom_req", rom_bus.rom_req, 0);
        chk("rst_insn_valid", insn_valid, 0);
        chk("rst_pc", pc, 0);
        chk("rst_halted", halted, 0);
        chk("rst_count", insn_count, 0);
        @(negedge clk);
        force_ack = 1'b0;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    rom_bus.rom_ack  = 1'b0;
    rom_bus.rom_data = '0;
    fill_plain();
    fork
      begin : driver
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("reset_pc", pc, 0);
        chk("reset_rom_req", rom_bus.rom_req, 0);
        chk("reset_rom_addr", rom_bus.rom_addr, 0);
        chk("reset_insn_valid", insn_valid, 0);
        chk("reset_halted", halted, 0);
        chk("reset_count", insn_count, 0);
        chk("reset_insn_out", insn_out, 0);
        reset = 1'b0;
        @(negedge clk);

        rand_waits = 0;
        // Straight-line code, ROM stall at address 5, halt at 6.
        fill_plain();
        rom_mem[6] = 9'b111_000001;
        do_run();
        // Absolute jumps 0 -> 10 -> 0x40, halt there.
        fill_plain();
        rom_mem[0]  = mk(1, 0, 0, 2);  dest_tab[2] = 8'd10;
        rom_mem[10] = mk(1, 0, 0, 3);  dest_tab[3] = 8'h40;
        rom_mem[8'h40] = 9'b111_000001;
        do_run();
        // Relative branch -3 at pc 10 with flag set lands on 7.
        fill_plain();
        rom_mem[0]  = mk(1, 0, 0, 2);  dest_tab[2] = 8'd10;
        rom_mem[10] = mk(0, 1, 1, 33); dest_tab[33] = 8'hFD;
        rom_mem[7]  = 9'b111_000001;
        do_run();
        // Same branch with flag clear falls through to 11.
        fill_plain();
        rom_mem[0]  = mk(1, 0, 0, 2);  dest_tab[2] = 8'd10;
        rom_mem[10] = mk(0, 1, 1, 4);  dest_tab[4] = 8'hFD;
        rom_mem[11] = 9'b111_000001;
        do_run();
        // Backward wrap from 2 to 0xFE, forward wrap 0xFF -> 0; never halts.
        fill_plain();
        rom_mem[2] = mk(0, 1, 1, 34);  dest_tab[34] = 8'hFC;
        do_run();

        rand_waits = 1;
        for (int r = 0; r < 16; r++) begin
          fill_random();
          do_run();
        end
        repeat (3) @(negedge clk);
      end
      begin : monitor
        exp_t e;
        int   w;
        forever begin
          @(posedge clk);
          #1;
          cyc++;
          if (insn_valid) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_exec", 1, 0);
            end else begin
              e = exp_q.pop_front();
              w = (wq.size() != 0) ? wq.pop_front() : -1;
              chk("exec_pc", pc, e.pc);
              chk("exec_insn", insn_out, e.insn);
              chk("exec_count", insn_count, e.idx);
              chk("exec_halted", halted, 0);
              chk("exec_gap", cyc - ((e.idx == 0) ? start_cyc : last_exec), 2 + w);
              last_exec = cyc;
            end
          end
        end
      end
      begin : rom_model
        int wl;
        bit in_req, stuck;
        wl = 0;
        in_req = 0;
        stuck = 0;
        forever begin
          @(negedge clk);
          #1;
          if (rom_bus.rom_req) begin
            if (!in_req) begin
              in_req = 1;
              stuck  = (exp_q.size() == 0);
              if (!stuck) begin
                if (rand_waits) wl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                else wl = (rom_bus.rom_addr == 8'd5) ? 3 : 0;
                wq.push_back(wl);
              end
            end
            if (!stuck) chk("rom_addr", rom_bus.rom_addr, exp_q[0].pc);
            if (!stuck && wl == 0) begin
              rom_bus.rom_ack  = 1'b1;
              rom_bus.rom_data = rom_mem[rom_bus.rom_addr];
              in_req = 0;
            end else begin
              rom_bus.rom_ack  = 1'b0;
              rom_bus.rom_data = 9'($urandom);
              if (!stuck) wl--;
            end
          end else begin
            in_req = 0;
            rom_bus.rom_ack  = force_ack | 1'($urandom_range(0, 1));
            rom_bus.rom_data = 9'($urandom);
          end
        end
      end
    join_any
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch sequencer for the SIWO core. Owns the program counter and fetches instructions from the instruction ROM over a req/ack handshake. It presents each instruction to the combinational control unit for exactly one cycle and consumes that unit's halt/branch/jump/relative/destBranchJump outputs in the same cycle. From those outputs and the compare flag it computes the next PC.

Parameters:
INSN_WIDTH, 9, instruction word width; matches the ROM data width.
DATA_WIDTH, 8, width of destBranchJump.
PC_WIDTH, 8, program counter and ROM address width.
CNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  begin or restart execution at PC 0; honoured only in IDLE or HALTED.
rom_req  output  1  ROM read request.
rom_addr  output  PC_WIDTH  ROM read address.
rom_ack  input  1  ROM data valid; rom_data is sampled in any cycle where rom_req && rom_ack.
rom_data  input  INSN_WIDTH  ROM read data.
insn_out  output  INSN_WIDTH  instruction presented to the control unit.
insn_valid  output  1  insn_out is being executed this cycle.
halt  input  1  from control unit; sampled only when insn_valid.
branch  input  1  from control unit; conditional on compare_flag.
jump  input  1  from control unit; unconditional.
relative  input  1  from control unit; 1 = PC-relative target, 0 = absolute target.
destBranchJump  input  DATA_WIDTH  from control unit; target or signed offset.
compare_flag  input  1  output of the compare flip-flop.
pc  output  PC_WIDTH  current program counter.
halted  output  1  core is in HALTED.
insn_count  output  CNT_WIDTH  instructions retired since the last start; saturating.

Behaviour:
Reset:
- State = IDLE; pc = 0; insn_out = 0; insn_count = 0.
- rom_req = 0, insn_valid = 0, halted = 0.
- rom_addr = pc at all times.

States:
- IDLE: wait for start. On start: pc <= 0, insn_count <= 0, go to REQ.
- REQ: rom_req = 1; rom_addr is held stable.
  - rom_ack = 0: stay in REQ.
  - rom_ack = 1: insn_out <= rom_data, go to EXEC. An ack in the first REQ cycle is legal.
- EXEC: insn_valid = 1 for exactly one cycle; rom_req = 0. The control-unit inputs are evaluated against insn_out this cycle.
  - insn_count increments by 1 (saturates at all-ones). A halting instruction is counted.
  - halt = 1: pc unchanged, go to HALTED.
  - Otherwise pc <= next_pc, go to REQ.
- HALTED: halted = 1. On start: pc <= 0, insn_count <= 0, go to REQ.

Next PC (applied only in EXEC without halt):
- taken = jump || (branch && compare_flag).
- Not taken: next_pc = pc + 1.
- Taken, relative = 0: next_pc = destBranchJump zero-extended or truncated to PC_WIDTH.
- Taken, relative = 1: next_pc = pc + sign_extend(destBranchJump) truncated to PC_WIDTH. The offset is relative to the branch instruction's own address.
- All PC arithmetic wraps modulo 2^PC_WIDTH; pc + 1 from all-ones wraps to 0.

Priority and ignored inputs:
- If both jump and branch are asserted, the jump wins.
- halt overrides branch and jump.
- halt, branch, jump and rom_ack are ignored outside the states that use them.
- start is ignored in REQ and EXEC.

Timing:
- Zero-wait ROM: 2 cycles per instruction.
- Each ROM wait cycle adds 1.
- First insn_valid occurs 2 cycles after the start cycle (with immediate ack).

Reset mid-operation:
- reset in REQ or EXEC returns to IDLE on that edge; rom_req is low from the next cycle.
- A late rom_ack arriving after reset is ignored.
- reset overrides start in the same cycle.

Test Plan:
1. Reset, then start with ROM zero-wait returning non-control words at addresses 0..3 -> insn_valid every 2nd cycle; rom_addr sequence 0,1,2,3; insn_count = 4 after the fourth EXEC.
2. ROM holds rom_ack low for 3 cycles at address 5 -> rom_req and rom_addr = 5 are held stable for 4 cycles; insn_out captures the data from the ack cycle; exactly one insn_valid.
3. pc = 10 with jump=1, relative=0, dest=0x40 -> next rom_addr = 0x40. pc = 10 with branch=1, relative=1, dest=0xFD (-3), compare_flag=1 -> rom_addr = 7. Same branch with compare_flag=0 -> rom_addr = 11.
4. pc = 0xFF, non-control instruction -> next rom_addr = 0x00. pc = 0x02 with relative branch, dest=0xFC, compare_flag=1 -> rom_addr = 0xFE.
5. halt=1 at pc = 6 -> halted = 1 and pc stays 6; rom_req stays 0 for 10 cycles; insn_count includes the halt. start -> pc = 0, insn_count = 0, fetch resumes at 0.
6. reset asserted in a REQ wait cycle, with rom_ack arriving one cycle later -> state is IDLE, rom_req = 0, insn_valid never asserts, pc = 0. start during EXEC is ignored.
